// File: rtl/pcie_us_cq_regfile.sv
// PCIe completer register file: services single-dword MemRd/MemWr on one BAR from the CQ
// stream and returns completions (or UR) on the CC stream, one request in flight at a time.
// state | meaning
// IDLE  | waiting for descriptor beat
// DRAIN | discarding remaining beats of a multi-beat request
// CPL   | completion presented on CC, waiting for tready
module pcie_us_cq_regfile #(
    parameter int AXIS_PCIE_DATA_WIDTH    = 512,
    parameter int AXIS_PCIE_KEEP_WIDTH    = AXIS_PCIE_DATA_WIDTH / 32,
    parameter int AXIS_PCIE_CQ_USER_WIDTH = 183,
    parameter int AXIS_PCIE_CC_USER_WIDTH = 81,
    parameter int REG_ADDR_WIDTH          = 6,
    parameter int BAR_ID                  = 0
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [AXIS_PCIE_DATA_WIDTH-1:0]    s_axis_cq_tdata,
    input  logic [AXIS_PCIE_KEEP_WIDTH-1:0]    s_axis_cq_tkeep,
    input  logic                               s_axis_cq_tlast,
    input  logic [AXIS_PCIE_CQ_USER_WIDTH-1:0] s_axis_cq_tuser,
    input  logic                               s_axis_cq_tvalid,
    output logic                               s_axis_cq_tready,
    output logic [AXIS_PCIE_DATA_WIDTH-1:0]    m_axis_cc_tdata,
    output logic [AXIS_PCIE_KEEP_WIDTH-1:0]    m_axis_cc_tkeep,
    output logic                               m_axis_cc_tlast,
    output logic [AXIS_PCIE_CC_USER_WIDTH-1:0] m_axis_cc_tuser,
    output logic                               m_axis_cc_tvalid,
    input  logic                               m_axis_cc_tready,
    output logic                               status_error_uncor
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_CPL   = 2'd2;
    localparam int         NREG     = 1 << REG_ADDR_WIDTH;
    localparam logic [2:0] BAR_SEL  = 3'(BAR_ID);

    logic [1:0]                      state_q, state_d;
    logic                            rdy_en_q;
    logic                            owed_q, owed_d;
    logic                            err_q, err_d;
    logic                            cc_valid_q, cc_valid_d;
    logic                            cc_last_q, cc_last_d;
    logic [AXIS_PCIE_KEEP_WIDTH-1:0] cc_keep_q, cc_keep_d;
    logic [AXIS_PCIE_DATA_WIDTH-1:0] cc_data_q, cc_data_d;
    logic [31:0]                     regs_q [NREG];

    logic [REG_ADDR_WIDTH-1:0] idx;
    logic [10:0]               dwc;
    logic [3:0]                rtype;
    logic [2:0]                bar;
    logic [3:0]                be;
    logic [31:0]               wdata;
    logic                      is_posted, req_ok, do_rd, do_wr;
    logic                      cq_fire, beat0;
    logic [1:0]                lo, hi;
    logic [2:0]                nbytes;
    logic [AXIS_PCIE_DATA_WIDTH-1:0] cc_desc;
    logic                      unused_ok;

    assign idx   = s_axis_cq_tdata[2 +: REG_ADDR_WIDTH];
    assign dwc   = s_axis_cq_tdata[74:64];
    assign rtype = s_axis_cq_tdata[78:75];
    assign bar   = s_axis_cq_tdata[114:112];
    assign wdata = s_axis_cq_tdata[159:128];
    assign be    = s_axis_cq_tuser[3:0];

    // Writes and messages (11xx) never get a completion, even when rejected
    assign is_posted = (rtype == 4'b0001) || (rtype[3:2] == 2'b11);
    assign req_ok    = (bar == BAR_SEL) && (dwc == 11'd1);
    assign do_rd     = (rtype == 4'b0000) && req_ok;
    assign do_wr     = (rtype == 4'b0001) && req_ok;

    assign s_axis_cq_tready = rdy_en_q && (state_q != ST_CPL);
    assign cq_fire          = s_axis_cq_tvalid && s_axis_cq_tready;
    assign beat0            = cq_fire && (state_q == ST_IDLE);

    always_comb begin
        lo = 2'd0;
        hi = 2'd0;
        if      (be[0]) lo = 2'd0;
        else if (be[1]) lo = 2'd1;
        else if (be[2]) lo = 2'd2;
        else if (be[3]) lo = 2'd3;
        if      (be[3]) hi = 2'd3;
        else if (be[2]) hi = 2'd2;
        else if (be[1]) hi = 2'd1;
        nbytes = {1'b0, hi} - {1'b0, lo} + 3'd1;
    end

    always_comb begin
        cc_desc          = '0;
        cc_desc[6:0]     = {s_axis_cq_tdata[6:2], lo};
        cc_desc[28:16]   = do_rd ? {10'd0, nbytes} : 13'd4;
        cc_desc[42:32]   = do_rd ? 11'd1 : 11'd0;
        cc_desc[45:43]   = do_rd ? 3'b000 : 3'b001;
        cc_desc[63:48]   = s_axis_cq_tdata[95:80];
        cc_desc[71:64]   = s_axis_cq_tdata[103:96];
        cc_desc[79:72]   = s_axis_cq_tdata[111:104];
        cc_desc[91:89]   = s_axis_cq_tdata[123:121];
        cc_desc[94:92]   = s_axis_cq_tdata[126:124];
        if (do_rd) cc_desc[127:96] = regs_q[idx];
    end

    always_comb begin
        state_d    = state_q;
        owed_d     = owed_q;
        err_d      = 1'b0;
        cc_valid_d = cc_valid_q;
        cc_last_d  = cc_last_q;
        cc_keep_d  = cc_keep_q;
        cc_data_d  = cc_data_q;
        case (state_q)
            ST_IDLE: begin
                if (beat0) begin
                    err_d = !(do_rd || do_wr);
                    if (!is_posted) begin
                        cc_data_d = cc_desc;
                        cc_keep_d = do_rd ? AXIS_PCIE_KEEP_WIDTH'(16'h000F)
                                          : AXIS_PCIE_KEEP_WIDTH'(16'h0007);
                        cc_last_d = 1'b1;
                    end
                    if (s_axis_cq_tlast) begin
                        if (!is_posted) begin
                            cc_valid_d = 1'b1;
                            state_d    = ST_CPL;
                        end
                    end else begin
                        owed_d  = !is_posted;
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (cq_fire && s_axis_cq_tlast) begin
                    owed_d = 1'b0;
                    if (owed_q) begin
                        cc_valid_d = 1'b1;
                        state_d    = ST_CPL;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_CPL: begin
                if (m_axis_cc_tready) begin
                    cc_valid_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rdy_en_q   <= 1'b0;
            owed_q     <= 1'b0;
            err_q      <= 1'b0;
            cc_valid_q <= 1'b0;
            cc_last_q  <= 1'b0;
            cc_keep_q  <= '0;
            cc_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            rdy_en_q   <= 1'b1;
            owed_q     <= owed_d;
            err_q      <= err_d;
            cc_valid_q <= cc_valid_d;
            cc_last_q  <= cc_last_d;
            cc_keep_q  <= cc_keep_d;
            cc_data_q  <= cc_data_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else if (beat0 && do_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) regs_q[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign m_axis_cc_tdata    = cc_data_q;
    assign m_axis_cc_tkeep    = cc_keep_q;
    assign m_axis_cc_tlast    = cc_last_q;
    assign m_axis_cc_tuser    = '0;
    assign m_axis_cc_tvalid   = cc_valid_q;
    assign status_error_uncor = err_q;

    assign unused_ok = ^{s_axis_cq_tdata[AXIS_PCIE_DATA_WIDTH-1:160], s_axis_cq_tdata[127],
                         s_axis_cq_tdata[120:115], s_axis_cq_tdata[79], s_axis_cq_tdata[63:0],
                         s_axis_cq_tkeep, s_axis_cq_tuser[AXIS_PCIE_CQ_USER_WIDTH-1:4]};

endmodule
